axis_req_arbiter: RTL
=====================

// Module: axis_req_arbiter
// PURPOSE
//  Merges NUM_CH requester AXI-stream request channels (core fetch, core data, boot loader)
//  into one memory-side req stream and routes the mem-side resp stream back to the issuing
//  channel in order. Sits between the core_wrapper streams and the memory/UART bridge.
//  It generalises the single req/resp pair to N channels, adding round-robin fairness and
//  bounded outstanding reads.
// PARAMETERS
//  NUM_CH       2    number of requester channels (1..8)
//  DATA_WIDTH   128  req/resp payload width
//  ORDER_DEPTH  8    max outstanding reads; power of 2, >=2
// PORTS
//  clk_in               in   1              single clock
//  rst_in               in   1              synchronous, active-high reset
//  ch_req_axis_valid    in   NUM_CH         per-channel request valid
//  ch_req_axis_ready    out  NUM_CH         per-channel request ready
//  ch_req_axis_tuser    in   NUM_CH         1 = write (no resp), 0 = read
//  ch_req_axis_data     in   NUM_CH*DW      channel c occupies bits [c*DW +: DW]
//  ch_resp_axis_valid   out  NUM_CH         per-channel response valid
//  ch_resp_axis_ready   in   NUM_CH         per-channel response ready
//  ch_resp_axis_tuser   out  NUM_CH         copy of mem_resp_axis_tuser
//  ch_resp_axis_data    out  NUM_CH*DW      copy of mem_resp_axis_data on every lane
//  mem_req_axis_valid   out  1              merged request valid
//  mem_req_axis_ready   in   1              memory accepts request
//  mem_req_axis_tuser   out  1              write flag of merged request
//  mem_req_axis_data    out  DW             merged request payload
//  mem_resp_axis_valid  in   1              memory response valid
//  mem_resp_axis_ready  out  1              arbiter accepts response
//  mem_resp_axis_tuser  in   1              passed through
//  mem_resp_axis_data   in   DW             passed through
//  err_orphan_resp      out  1              sticky: response arrived with no outstanding read
//  grant_count          out  NUM_CH*32      per-channel grant counters (REQ_ARB_STATS_EN)
// BEHAVIOUR
//  Reset: mem_req_axis_valid=0, ch_req_axis_ready=0, ch_resp_axis_valid=0,
//   err_orphan_resp=0, grant_count=0, order FIFO empty, rr pointer=0, out register empty.
//  Request path: one-entry output register (valid,tuser,data,src). Latency 1 cycle.
//   Register "free" = empty, or (valid & mem_req_axis_ready) this cycle.
//  Arbitration: when free, grant goes to the first channel at or after rr_ptr with
//   valid=1 and eligible. Eligible = tuser=1, or order FIFO not full.
//   Only the granted channel sees ready=1; all others see 0.
//  On grant handshake: load register; if tuser=0, push channel id into order FIFO.
//   rr_ptr <= (grant+1) mod NUM_CH. With no grant, rr_ptr holds.
//  mem_req outputs come only from the register; stable while valid & !ready.
//  Full FIFO: reads are blocked even if a pop occurs the same cycle (conservative).
//   Writes still pass.
//  Response path, combinational, 0 latency. With FIFO non-empty and head=h:
//   ch_resp_axis_valid[h]=mem_resp_axis_valid, other lanes 0,
//   mem_resp_axis_ready=ch_resp_axis_ready[h]. Handshake pops the FIFO.
//  With FIFO empty: all ch_resp valid=0, mem_resp_axis_ready=1.
//   A response accepted here is dropped and sets err_orphan_resp (cleared only by reset).
//  Push and pop in the same cycle: count unchanged; legal at any non-full level.
//  Reset mid-operation: in-flight request and order state discarded. Memory is also
//   reset by rst_in, so late responses are not expected.
// CONFIGURATION
//  REQ_ARB_STATS_EN defined: grant_count[c] increments (wraps at 2^32) on each
//   channel-c request handshake.
//  REQ_ARB_STATS_EN undefined: counters not built; grant_count tied to 0.
// STRUCTURE
//  Package mem_arb_pkg: ch_id_t (logic[$clog2(MAX_CH)-1:0], MAX_CH=8),
//   TUSER_WRITE=1'b1, TUSER_READ=1'b0.
//  Sub-module order_fifo: sync FIFO of ch_id_t, depth ORDER_DEPTH,
//   full/empty/count outputs, same-cycle push+pop support.
// TESTING
//  1 ch0 read, data 0xA5.., mem_ready=1 -> mem_req valid next cycle with tuser=0;
//    resp 0x11.. appears on ch0 only.
//  2 ch0 and ch1 both valid, continuous reads -> grants alternate 0,1,0,1;
//    responses return to 0,1,0,1 in order.
//  3 mem_req_axis_ready=0 for 5 cycles -> data/tuser held constant;
//    no further ch ready asserted.
//  4 ORDER_DEPTH=8, issue 8 reads, no resp -> 9th read stalled; a write on ch1 still passes;
//    one resp frees the slot.
//  5 mem resp with no outstanding read -> accepted, dropped, err_orphan_resp=1 until rst_in.
//  6 REQ_ARB_STATS_EN, 3 grants ch0, 2 ch1 -> grant_count={2,3};
//    assert rst_in mid-burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the request arbiter: channel id width and tuser encodings.
// A channel id fits the largest supported channel count so sub-blocks agree on width.
package mem_arb_pkg;
  localparam int MAX_CH = 8;
  typedef logic [$clog2(MAX_CH)-1:0] ch_id_t;
  localparam logic TUSER_WRITE = 1'b1;
  localparam logic TUSER_READ  = 1'b0;
endpackage

// File: rtl/order_fifo.sv
// Purpose: in-order record of which channel issued each outstanding read.
// Latency: push visible at head next cycle. Backpressure: push ignored when full, pop ignored when empty.
module order_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        push,
  input  ch_id_t      push_id,
  input  logic        pop,
  output ch_id_t      head_id,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  ch_id_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_req_arbiter.sv
// Purpose: round-robin merge of NUM_CH req streams onto one mem stream, resps routed back in order.
// Latency: req 1 cycle (output register), resp 0 cycles. Backpressure: reads stall while order FIFO is full;
// writes still pass. Optional per-channel grant counters under REQ_ARB_STATS_EN.
module axis_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DATA_WIDTH  = 128,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_CH-1:0]            ch_req_axis_valid,
  output logic [NUM_CH-1:0]            ch_req_axis_ready,
  input  logic [NUM_CH-1:0]            ch_req_axis_tuser,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_req_axis_data,
  output logic [NUM_CH-1:0]            ch_resp_axis_valid,
  input  logic [NUM_CH-1:0]            ch_resp_axis_ready,
  output logic [NUM_CH-1:0]            ch_resp_axis_tuser,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_resp_axis_data,
  output logic                         mem_req_axis_valid,
  input  logic                         mem_req_axis_ready,
  output logic                         mem_req_axis_tuser,
  output logic [DATA_WIDTH-1:0]        mem_req_axis_data,
  input  logic                         mem_resp_axis_valid,
  output logic                         mem_resp_axis_ready,
  input  logic                         mem_resp_axis_tuser,
  input  logic [DATA_WIDTH-1:0]        mem_resp_axis_data,
  output logic                         err_orphan_resp,
  output logic [NUM_CH*32-1:0]         grant_count
);

  localparam int CW = $clog2(ORDER_DEPTH) + 1;

  typedef struct packed {
    logic                  user;
    logic [DATA_WIDTH-1:0] dat;
  } req_slot_t;

  req_slot_t           slot_q;
  logic                slot_vld;
  logic                slot_free;
  ch_id_t              rr_ptr;
  logic [NUM_CH-1:0]   elig;
  logic                gnt_vld;
  ch_id_t              gnt_id;
  ch_id_t              hi_id;
  logic                hi_hit;
  logic [NUM_CH-1:0]   gnt_oh;
  req_slot_t           gnt_slot;
  logic                req_hs;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  ch_id_t              head_id;
  logic [CW-1:0]       fifo_cnt;
  logic                unused_fifo_cnt;

  assign slot_free = !slot_vld || mem_req_axis_ready;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = ch_req_axis_valid[c] && (ch_req_axis_tuser[c] == TUSER_WRITE || !fifo_full);
    end
  end

  // Two-pass round robin: lowest eligible id at/after rr_ptr, else lowest eligible overall.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    hi_hit  = 1'b0;
    hi_id   = '0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (elig[c]) begin
        gnt_vld = 1'b1;
        gnt_id  = ch_id_t'(c);
        if (ch_id_t'(c) >= rr_ptr) begin
          hi_hit = 1'b1;
          hi_id  = ch_id_t'(c);
        end
      end
    end
    if (hi_hit) gnt_id = hi_id;
  end

  always_comb begin
    gnt_oh   = '0;
    gnt_slot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_vld && gnt_id == ch_id_t'(c)) begin
        gnt_oh[c]     = 1'b1;
        gnt_slot.user = ch_req_axis_tuser[c];
        gnt_slot.dat  = ch_req_axis_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is held low while in reset so nothing handshakes against a clearing datapath.
  assign ch_req_axis_ready = (slot_free && !rst_in) ? gnt_oh : '0;
  assign req_hs            = gnt_vld && slot_free && !rst_in;
  assign fifo_push         = req_hs && (gnt_slot.user == TUSER_READ);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_vld <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      if (slot_free) slot_vld <= req_hs;
      if (req_hs) begin
        slot_q <= gnt_slot;
        rr_ptr <= (gnt_id == ch_id_t'(NUM_CH-1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  assign mem_req_axis_valid = slot_vld;
  assign mem_req_axis_tuser = slot_q.user;
  assign mem_req_axis_data  = slot_q.dat;

  order_fifo #(.DEPTH(ORDER_DEPTH)) u_order_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push    (fifo_push),
    .push_id (gnt_id),
    .pop     (fifo_pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign unused_fifo_cnt = ^fifo_cnt;

  // With nothing outstanding the response is swallowed so memory never stalls on it.
  always_comb begin
    ch_resp_axis_valid  = '0;
    mem_resp_axis_ready = 1'b1;
    if (!fifo_empty) begin
      mem_resp_axis_ready = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (head_id == ch_id_t'(c)) begin
          ch_resp_axis_valid[c] = mem_resp_axis_valid;
          mem_resp_axis_ready   = ch_resp_axis_ready[c];
        end
      end
    end
  end

  assign fifo_pop           = !fifo_empty && mem_resp_axis_valid && mem_resp_axis_ready;
  assign ch_resp_axis_tuser = {NUM_CH{mem_resp_axis_tuser}};
  assign ch_resp_axis_data  = {NUM_CH{mem_resp_axis_data}};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_orphan_resp <= 1'b0;
    end else if (fifo_empty && mem_resp_axis_valid) begin
      err_orphan_resp <= 1'b1;
    end
  end

`ifdef REQ_ARB_STATS_EN
  logic [NUM_CH-1:0][31:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_hs && gnt_oh[c]) cnt_q[c] <= cnt_q[c] + 32'd1;
      end
    end
  end

  assign grant_count = cnt_q;
`else
  assign grant_count = '0;
`endif

endmodule
